// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} flush_state_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
endpackage

// File: rtl/pipe_sched_md_timer.sv
// Multiply/divide occupancy timer: holds E until the op's fixed latency elapses.
module md_timer
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic E_valid,
    input  logic E_md_op,
    input  logic E_md_div,
    input  logic advance,
    input  logic flush,
    output logic E_ready,
    output logic md_busy
);
    localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    md_state_t     mdState;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdState <= IDLE;
            cnt     <= '0;
        end else if (flush) begin
            mdState <= IDLE;
        end else begin
            case (mdState)
                IDLE: if (E_valid && E_md_op) begin
                    mdState <= BUSY;
                    cnt     <= E_md_div ? DIV_LOAD : MULT_LOAD;
                end
                BUSY: begin
                    cnt <= cnt - ONE;
                    if (cnt == ONE) mdState <= DONE;
                end
                DONE: if (E_valid && advance) mdState <= IDLE;
                default: mdState <= IDLE;
            endcase
        end
    end

    assign E_ready = !(E_valid && E_md_op) || (mdState == DONE);
    assign md_busy = (mdState != IDLE);
endmodule

// File: rtl/pipe_sched.sv
// Five-stage pipeline sequencing: handshakes, memory outstanding tracking,
// and the exception flush/redirect sequence.
module pipe_sched
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 32,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] EXC_VEC  = pipe_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_valid,
    input  logic        D_valid,
    input  logic        E_valid,
    input  logic        M_valid,
    input  logic        W_valid,
    input  logic        D_hazard,
    input  logic        E_md_op,
    input  logic        E_md_div,
    input  logic        M_excpt,
    input  logic        M_eret,
    input  logic [31:0] epc,
    input  logic        mem_req,
    input  logic        mem_resp,
    output logic        F_allowin,
    output logic        D_allowin,
    output logic        E_allowin,
    output logic        M_allowin,
    output logic        W_allowin,
    output logic        F_to_D_valid,
    output logic        D_to_E_valid,
    output logic        E_to_M_valid,
    output logic        M_to_W_valid,
    output logic        respon,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mem_req_allow,
    output logic        mem_resp_discard,
    output logic        md_busy
);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);

    flush_state_t  flushState;
    logic [31:0]   target;
    logic [OW-1:0] outst;
    logic [OW-1:0] nextOutst;
    logic          respEff;
    logic          holdAll;
    logic          dReady;
    logic          eReady;
    logic          mReady;
    logic          wReady;

    md_timer #(
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .E_valid (E_valid),
        .E_md_op (E_md_op),
        .E_md_div(E_md_div),
        .advance (M_allowin),
        .flush   (respon),
        .E_ready (eReady),
        .md_busy (md_busy)
    );

    assign holdAll = (flushState != RUN);
    assign dReady  = !D_hazard;
    assign mReady  = (outst == '0) || ((outst == OUT_ONE) && mem_resp);
    assign wReady  = 1'b1;

    assign W_allowin = !W_valid || wReady;
    assign M_allowin = !holdAll && (!M_valid || (mReady && W_allowin));
    assign E_allowin = !holdAll && (!E_valid || (eReady && M_allowin));
    assign D_allowin = !holdAll && (!D_valid || (dReady && E_allowin));
    assign F_allowin = !holdAll && (!F_valid || D_allowin);

    assign F_to_D_valid = F_valid;
    assign D_to_E_valid = D_valid && dReady;
    assign E_to_M_valid = E_valid && eReady;
    assign M_to_W_valid = M_valid && mReady && !M_excpt;

    // Gated by reset so an exception seen during reset never flushes.
    assign respon = !reset && (flushState == RUN) && M_valid && M_excpt;

    assign respEff = mem_resp && (outst != '0);
    always_comb begin
        nextOutst = outst;
        if (mem_req && !respEff) nextOutst = outst + OUT_ONE;
        else if (!mem_req && respEff) nextOutst = outst - OUT_ONE;
    end

    assign mem_req_allow    = (outst < OUT_MAX);
    assign mem_resp_discard = (flushState == DRAIN) && mem_resp;
    assign redirect_valid   = (flushState == REDIRECT);
    assign redirect_pc      = target;

    always_ff @(posedge clk) begin
        if (reset) begin
            flushState <= RUN;
            target     <= EXC_VEC;
            outst      <= '0;
        end else begin
            outst <= nextOutst;
            case (flushState)
                RUN: if (respon) begin
                    target     <= M_eret ? epc : EXC_VEC;
                    flushState <= (nextOutst != '0) ? DRAIN : REDIRECT;
                end
                DRAIN:    if (nextOutst == '0) flushState <= REDIRECT;
                REDIRECT: flushState <= RUN;
                default:  flushState <= RUN;
            endcase
        end
    end

    // Issuing a request with the outstanding table already full is a protocol error.
    always_ff @(posedge clk) begin
        if (!reset && mem_req) assert (outst != OUT_MAX);
    end
endmodule

// File: doc/pipe_sched.md
# pipe_sched

Central sequencing controller for the five-stage MIPS pipeline (F/D/E/M/W). It computes every stage's `*_allowin` and `*_to_*_valid` handshake from per-stage valid and stall conditions. It owns the multiply/divide busy counter and the data-memory outstanding-request counter, and it runs the exception-flush sequence that drives `respon` and the fetch redirect. Stage registers keep their own valid and payload flops; this block only decides when they advance or clear.

## Interface
- `MULT_CYC`, 5, E-stage cycles for mult/multu (≥2)
- `DIV_CYC`, 32, E-stage cycles for div/divu (≥2)
- `MAX_OUT`, 2, maximum outstanding data-memory requests (≥1)
- `EXC_VEC`, 32'hBFC0_0380, exception entry PC

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `F_valid, D_valid, E_valid, M_valid, W_valid`  in  1 each  stage valid bits
- `D_hazard`  in  1  load-use hazard in D
- `E_md_op`, `E_md_div`  in  1 each  E holds mult/div; 1 = divide
- `M_excpt`, `M_eret`  in  1 each  M instruction raises exception / is eret
- `epc`  in  32  CP0 EPC
- `mem_req`  in  1  data request accepted this cycle
- `mem_resp`  in  1  data response this cycle
- `F_allowin, D_allowin, E_allowin, M_allowin, W_allowin`  out  1 each
- `F_to_D_valid, D_to_E_valid, E_to_M_valid, M_to_W_valid`  out  1 each
- `respon`  out  1  flush pulse to all stage registers
- `redirect_valid`  out  1, `redirect_pc`  out  32  fetch redirect
- `mem_req_allow`  out  1  outstanding count < MAX_OUT
- `mem_resp_discard`  out  1  response belongs to a flushed instruction
- `md_busy`  out  1  MD FSM not in IDLE

## Operation
- Ready-go: D_ready = !D_hazard; E_ready = !(E_valid && E_md_op) || md_state==DONE; M_ready = outst==0 || (outst==1 && mem_resp); W_ready = 1.
- X_allowin = !X_valid || (X_ready && next_allowin); W_allowin = 1. X_to_next_valid = X_valid && X_ready. M_to_W_valid is additionally masked by !M_excpt.
- All allowins are forced to 0 in DRAIN and REDIRECT; W_allowin stays 1.
- MD FSM IDLE/BUSY/DONE:
  - IDLE→BUSY when E_valid && E_md_op; loads cnt = (E_md_div ? DIV_CYC : MULT_CYC) − 1.
  - BUSY: decrements cnt; moves to DONE when cnt==1.
  - DONE→IDLE when E_valid && E_ready && M_allowin.
  - respon forces IDLE from any state.
- Outstanding counter `outst`, width clog2(MAX_OUT+1): +1 on mem_req, −1 on mem_resp, unchanged when both occur in the same cycle. mem_req at outst==MAX_OUT is a protocol violation (asserted). mem_resp at outst==0 is ignored.
- Flush FSM RUN/DRAIN/REDIRECT:
  - respon = (state==RUN) && M_valid && M_excpt, combinational. An eret arrives with M_excpt set.
  - On respon: latch target = M_eret ? epc : EXC_VEC. Go to DRAIN if the next outst > 0, else to REDIRECT.
  - DRAIN: mem_resp_discard = mem_resp; move to REDIRECT once outst reaches 0.
  - REDIRECT: redirect_valid = 1 and redirect_pc = target for exactly one cycle, then RUN.

## Timing
- Reset values: flush FSM in RUN, MD FSM in IDLE, cnt=0, outst=0, target=EXC_VEC, respon=0, redirect_valid=0, md_busy=0, mem_resp_discard=0.
- Allowin and valid outputs are combinational from the state; after reset with all valids 0, every allowin = 1.
- MD latency: op enters E at cycle t; E_ready first goes high at t+MULT_CYC or t+DIV_CYC.
- Exception latency:
  - respon is high in the same cycle M shows the exception, so stage registers clear on that edge.
  - With outst==0, redirect_valid is high at t+1.
  - With outst==n, redirect_valid is high one cycle after the last response.
- An exception occurring while reset is asserted is ignored; reset wins.
- M_excpt during DRAIN or REDIRECT produces no second respon.

## Structure
- Shared package `pipe_pkg`:
  - enum `flush_state_t` {RUN, DRAIN, REDIRECT}
  - enum `md_state_t` {IDLE, BUSY, DONE}
  - constant EXC_VEC
- Sub-module `md_timer`: MD FSM plus counter; ports E_valid, E_md_op, E_md_div, advance, flush → E_ready, md_busy. The rest of the block is flat.

## Test plan
- Reset, all valids 0 → all allowins 1, respon 0, redirect_valid 0, outst 0.
- mult in E at cycle 10 with M empty → E_ready 0 on cycles 10–14, 1 at 15; E_to_M_valid at 15; md_busy back to 0 at 16.
- Load-use: D_valid=E_valid=1, D_hazard=1 → D_allowin 0, F_allowin 0, D_to_E_valid 0. Release hazard → advance next edge.
- Exception with outst=0, M_eret=0 → respon 1 for one cycle, M_to_W_valid 0; next cycle redirect_valid 1, redirect_pc BFC00380.
- Exception with outst=2 → DRAIN. Responses at +3 and +5 each give mem_resp_discard 1. redirect_valid 1 at +6 with pc=epc (eret case).
- Simultaneous mem_req and mem_resp at outst=1 → outst stays 1, M_ready 1 that cycle.
